lightshow_sequencer: RTL and testbench
======================================

Name: lightshow_sequencer

Overview:
AXI4-Lite master that drives one frame update into the lightshow peripheral with no CPU involvement. Holds a local pixel buffer loaded through a simple write port. On i_start it programs the clock divider, writes i_frame_len pixel words, sets the control start bit, then polls status until the shift-out completes. Sits between a pattern source and the lightshow AXI-Lite slave port, as its sole master.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width and pixel word width
PIXEL_COUNT, 16, pixel buffer depth; maximum frame length
BASE_ADDR, 32'h0, lightshow base address
REG_CONTROL, 32'h00, control register offset; bit0 = start
REG_STATUS, 32'h04, status register offset; bit0 = busy
REG_CLK_DIV, 32'h08, clock divider register offset
REG_PIXEL_BASE, 32'h40, offset of pixel 0; pixel n is at +4*n
CLK_DIV, 10, value written to REG_CLK_DIV
POLL_LIMIT, 1024, maximum status reads before timeout

Ports:
i_axi_clk  in  1  clock
i_axi_rst  in  1  reset, asynchronous, active-low
i_start  in  1  start one frame; sampled only in IDLE
i_frame_len  in  $clog2(PIXEL_COUNT+1)  pixels to send; latched on start
i_pix_we  in  1  pixel buffer write enable
i_pix_addr  in  $clog2(PIXEL_COUNT)  pixel buffer address
i_pix_data  in  DATA_WIDTH  pixel buffer data
o_busy  out  1  high from the accepted start until DONE
o_done  out  1  one-cycle pulse on successful completion
o_error  out  1  sticky error flag; cleared by the next accepted start
o_err_code  out  2  01 = bad bresp, 10 = bad rresp, 11 = poll timeout
o_awvalid/o_awaddr/i_awready  out/out/in  1/ADDR_WIDTH/1  write address channel
o_wvalid/i_wready/o_wstrb/o_wdata  out/in/out/out  1/1/DATA_WIDTH/8/DATA_WIDTH  write data channel
i_bvalid/o_bready/i_bresp  in/out/in  1/1/2  write response channel
o_arvalid/i_arready/o_araddr  out/in/out  1/1/ADDR_WIDTH  read address channel
i_rvalid/o_rready/i_rresp/i_rdata  in/out/in/in  1/1/2/DATA_WIDTH  read data channel

Behaviour:
- Reset (async assert, sync deassert): all valid/ready outputs 0; addresses, wdata and err_code 0; o_busy, o_done and o_error 0; FSM in IDLE. Pixel buffer contents are undefined after reset.
- Pixel buffer: synchronous write on i_pix_we, accepted in any state. A write to the pixel index currently being issued does not affect the beat in flight, because wdata is latched when the beat starts.
- States: IDLE -> WR_CLKDIV -> WR_PIXEL (repeats i_frame_len times) -> WR_CTRL -> RD_STATUS -> IDLE.
- i_start in IDLE: latch frame_len, clear o_error, assert o_busy the next cycle.
- frame_len = 0: skip WR_PIXEL.
- frame_len > PIXEL_COUNT: clamp to PIXEL_COUNT.
- Write beat:
  - Assert o_awvalid and o_wvalid in the same cycle, with o_wstrb all ones.
  - Each valid drops the cycle after its own handshake; AW and W may complete in either order.
  - After both complete, assert o_bready and wait for i_bvalid.
  - One outstanding transaction at most; no valid is ever deasserted before its handshake.
- Read beat: assert o_arvalid until i_arready; then o_rready until i_rvalid.
- Addresses: BASE_ADDR + REG_x. Pixel n goes to BASE_ADDR + REG_PIXEL_BASE + 4*n, n incrementing from 0.
- WR_CTRL writes 32'h1.
- RD_STATUS:
  - rdata bit0 = 1: reissue the read the next cycle and increment the poll counter.
  - rdata bit0 = 0: go to IDLE, pulse o_done, drop o_busy the same cycle.
- Timeout: if the poll counter reaches POLL_LIMIT with busy still set, set o_error and o_err_code = 11, then go to IDLE.
- Response errors: bresp != 00 sets err_code 01; rresp != 00 sets err_code 10. Either one aborts to IDLE after the response handshake; no further beats are issued and o_done is not pulsed.
- i_start while busy is ignored.
- Reset mid-transaction drops all valids immediately; the slave is also reset.

Optional Feature:
LIGHTSHOW_SEQ_AUTO_REPEAT_EN
- Defined: adds parameter REPEAT_PERIOD (default 1000) and input i_auto (1 bit).
- After a successful completion with i_auto = 1, a down-counter loaded with REPEAT_PERIOD expires and the FSM restarts as if i_start had been asserted, using the latched frame_len.
- Deasserting i_auto cancels the pending restart.
- After an error there is no automatic restart.
- Undefined: there is no i_auto port, and only i_start begins a frame.

Test Plan:
1. Load pixels 0..3 = 32'hA0..A3, frame_len = 4, start, slave always ready, status busy for 3 reads.
   -> writes in order: 0x08 = 10, 0x40..0x4C = A0..A3, 0x00 = 1; then 4 reads of 0x04; one o_done pulse; o_error = 0.
2. Slave delays awready 3 cycles while wready is immediate, then the reverse order.
   -> o_wvalid drops after its own handshake, o_bready only after both, same address/data sequence.
3. bresp = 10 on the first pixel write.
   -> o_error = 1, err_code = 01, no further AW, no o_done, o_busy drops.
4. Status stuck busy, POLL_LIMIT = 8.
   -> exactly 8 reads, err_code = 11; a following start clears o_error.
5. frame_len = 0, then frame_len = 20 with PIXEL_COUNT = 16.
   -> no pixel writes in the first frame; exactly 16 pixel writes in the second.
6. Reset asserted mid-frame while o_awvalid is high, then start after release.
   -> all outputs 0 asynchronously; the next frame runs a full sequence from WR_CLKDIV.

Source files
------------

// File: rtl/lightshow_sequencer.sv
// AXI4-Lite master that programs the lightshow peripheral for one frame: clock divider, pixels, start, status poll.
// Optional auto-repeat after successful frames: define LIGHTSHOW_SEQ_AUTO_REPEAT_EN.
module lightshow_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PIXEL_COUNT    = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [31:0] REG_CONTROL    = 32'h00,
  parameter logic [31:0] REG_STATUS     = 32'h04,
  parameter logic [31:0] REG_CLK_DIV    = 32'h08,
  parameter logic [31:0] REG_PIXEL_BASE = 32'h40,
  parameter logic [31:0] CLK_DIV        = 32'd10,
`ifdef LIGHTSHOW_SEQ_AUTO_REPEAT_EN
  parameter int unsigned REPEAT_PERIOD  = 1000,
`endif
  parameter int unsigned POLL_LIMIT     = 1024
) (
  input  logic                             i_axi_clk,
  input  logic                             i_axi_rst,
`ifdef LIGHTSHOW_SEQ_AUTO_REPEAT_EN
  input  logic                             i_auto,
`endif
  input  logic                             i_start,
  input  logic [$clog2(PIXEL_COUNT+1)-1:0] i_frame_len,
  input  logic                             i_pix_we,
  input  logic [$clog2(PIXEL_COUNT)-1:0]   i_pix_addr,
  input  logic [DATA_WIDTH-1:0]            i_pix_data,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_error,
  output logic [1:0]                       o_err_code,
  output logic                             o_awvalid,
  output logic [ADDR_WIDTH-1:0]            o_awaddr,
  input  logic                             i_awready,
  output logic                             o_wvalid,
  input  logic                             i_wready,
  output logic [DATA_WIDTH/8-1:0]          o_wstrb,
  output logic [DATA_WIDTH-1:0]            o_wdata,
  input  logic                             i_bvalid,
  output logic                             o_bready,
  input  logic [1:0]                       i_bresp,
  output logic                             o_arvalid,
  input  logic                             i_arready,
  output logic [ADDR_WIDTH-1:0]            o_araddr,
  input  logic                             i_rvalid,
  output logic                             o_rready,
  input  logic [1:0]                       i_rresp,
  input  logic [DATA_WIDTH-1:0]            i_rdata
);

  localparam int unsigned LW = $clog2(PIXEL_COUNT + 1);
  localparam int unsigned IW = $clog2(PIXEL_COUNT);
  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(BASE_ADDR + REG_CONTROL);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(BASE_ADDR + REG_STATUS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CLKDIV = ADDR_WIDTH'(BASE_ADDR + REG_CLK_DIV);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PIX    = ADDR_WIDTH'(BASE_ADDR + REG_PIXEL_BASE);
`ifdef LIGHTSHOW_SEQ_AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_PERIOD + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_CLKDIV = 3'd1,
    S_WR_PIXEL  = 3'd2,
    S_WR_CTRL   = 3'd3,
    S_RD_STATUS = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    LK_NONE   = 2'd0,
    LK_CLKDIV = 2'd1,
    LK_PIXEL  = 2'd2,
    LK_CTRL   = 2'd3
  } launch_t;

  state_t                  state_q, state_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic                    busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [LW-1:0]           len_q, len_d;
  logic [IW-1:0]           pix_idx_q, pix_idx_d;
  logic [PW-1:0]           poll_cnt_q, poll_cnt_d;
`ifdef LIGHTSHOW_SEQ_AUTO_REPEAT_EN
  logic                    rep_pend_q, rep_pend_d;
  logic [RW-1:0]           rep_cnt_q, rep_cnt_d;
`endif

  logic [DATA_WIDTH-1:0]   pix_mem [PIXEL_COUNT];
  logic                    begin_s, launch_s, abort_s, pix_last_s;
  launch_t                 launch_kind_s;
  logic [1:0]              abort_code_s;
  logic [LW-1:0]           clamp_len_s;
  logic [ADDR_WIDTH-1:0]   launch_addr_s;
  logic [DATA_WIDTH-1:0]   launch_data_s;
  logic                    unused_rdata_s;

  // Only bit0 of the status word carries meaning.
  assign unused_rdata_s = ^i_rdata[DATA_WIDTH-1:1];
  assign clamp_len_s    = (i_frame_len > LW'(PIXEL_COUNT)) ? LW'(PIXEL_COUNT) : i_frame_len;
  assign pix_last_s     = (LW'(pix_idx_q) + LW'(1)) == len_q;

  // Pixel buffer: write port is independent of the sequencer state.
  always_ff @(posedge i_axi_clk) begin
    if (i_pix_we) begin
      pix_mem[i_pix_addr] <= i_pix_data;
    end
  end

  // Next-state, AXI channel control and status flag logic.
  always_comb begin
    state_d = state_q;       awvalid_d = awvalid_q;   wvalid_d = wvalid_q;
    bready_d = bready_q;     arvalid_d = arvalid_q;   rready_d = rready_q;
    awaddr_d = awaddr_q;     wdata_d = wdata_q;       wstrb_d = wstrb_q;
    araddr_d = araddr_q;     busy_d = busy_q;         done_d = 1'b0;
    error_d = error_q;       err_code_d = err_code_q; len_d = len_q;
    pix_idx_d = pix_idx_q;   poll_cnt_d = poll_cnt_q;
`ifdef LIGHTSHOW_SEQ_AUTO_REPEAT_EN
    rep_pend_d = rep_pend_q; rep_cnt_d = rep_cnt_q;
`endif
    begin_s = 1'b0;          launch_kind_s = LK_NONE;
    abort_s = 1'b0;          abort_code_s = 2'b00;
    launch_addr_s = {ADDR_WIDTH{1'b0}};
    launch_data_s = {DATA_WIDTH{1'b0}};

    case (state_q)
      S_IDLE: begin
`ifdef LIGHTSHOW_SEQ_AUTO_REPEAT_EN
        if (i_start) begin
          len_d      = clamp_len_s;
          begin_s    = 1'b1;
          rep_pend_d = 1'b0;
        end else if (rep_pend_q && i_auto) begin
          if (rep_cnt_q == {RW{1'b0}}) begin
            begin_s    = 1'b1;
            rep_pend_d = 1'b0;
          end else begin
            rep_cnt_d = rep_cnt_q - RW'(1);
          end
        end else begin
          rep_pend_d = 1'b0;
        end
`else
        if (i_start) begin
          len_d   = clamp_len_s;
          begin_s = 1'b1;
        end else begin
          begin_s = 1'b0;
        end
`endif
        if (begin_s) begin
          busy_d        = 1'b1;
          error_d       = 1'b0;
          err_code_d    = 2'b00;
          state_d       = S_WR_CLKDIV;
          launch_kind_s = LK_CLKDIV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_CLKDIV, S_WR_PIXEL, S_WR_CTRL: begin
        if (awvalid_q && i_awready) awvalid_d = 1'b0;
        else                        awvalid_d = awvalid_q;
        if (wvalid_q && i_wready) wvalid_d = 1'b0;
        else                      wvalid_d = wvalid_q;
        if (bready_q) begin
          if (i_bvalid) begin
            bready_d = 1'b0;
            if (i_bresp != 2'b00) begin
              abort_s      = 1'b1;
              abort_code_s = 2'b01;
            end else begin
              case (state_q)
                S_WR_CLKDIV: begin
                  if (len_q == {LW{1'b0}}) begin
                    state_d       = S_WR_CTRL;
                    launch_kind_s = LK_CTRL;
                  end else begin
                    state_d       = S_WR_PIXEL;
                    pix_idx_d     = {IW{1'b0}};
                    launch_kind_s = LK_PIXEL;
                  end
                end
                S_WR_PIXEL: begin
                  if (pix_last_s) begin
                    state_d       = S_WR_CTRL;
                    launch_kind_s = LK_CTRL;
                  end else begin
                    pix_idx_d     = pix_idx_q + IW'(1);
                    launch_kind_s = LK_PIXEL;
                  end
                end
                S_WR_CTRL: begin
                  state_d    = S_RD_STATUS;
                  arvalid_d  = 1'b1;
                  araddr_d   = ADDR_STATUS;
                  poll_cnt_d = {PW{1'b0}};
                end
                default: state_d = S_IDLE;
              endcase
            end
          end else begin
            bready_d = 1'b1;
          end
        end else if ((!awvalid_q || i_awready) && (!wvalid_q || i_wready)) begin
          // Both address and data handshakes are complete by the end of this cycle.
          bready_d = 1'b1;
        end else begin
          bready_d = 1'b0;
        end
      end
      S_RD_STATUS: begin
        if (arvalid_q) begin
          if (i_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
          end else begin
            arvalid_d = 1'b1;
          end
        end else if (rready_q && i_rvalid) begin
          rready_d = 1'b0;
          if (i_rresp != 2'b00) begin
            abort_s      = 1'b1;
            abort_code_s = 2'b10;
          end else if (i_rdata[0]) begin
            if (poll_cnt_q == PW'(POLL_LIMIT - 1)) begin
              abort_s      = 1'b1;
              abort_code_s = 2'b11;
            end else begin
              poll_cnt_d = poll_cnt_q + PW'(1);
              arvalid_d  = 1'b1;
            end
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
`ifdef LIGHTSHOW_SEQ_AUTO_REPEAT_EN
            rep_pend_d = i_auto;
            rep_cnt_d  = RW'(REPEAT_PERIOD);
`endif
          end
        end else begin
          rready_d = rready_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // wdata is captured here so later buffer writes cannot disturb a beat in flight.
    case (launch_kind_s)
      LK_CLKDIV: begin
        launch_addr_s = ADDR_CLKDIV;
        launch_data_s = DATA_WIDTH'(CLK_DIV);
      end
      LK_PIXEL: begin
        launch_addr_s = ADDR_PIX + ADDR_WIDTH'({pix_idx_d, 2'b00});
        launch_data_s = pix_mem[pix_idx_d];
      end
      LK_CTRL: begin
        launch_addr_s = ADDR_CTRL;
        launch_data_s = DATA_WIDTH'(32'h1);
      end
      default: launch_data_s = {DATA_WIDTH{1'b0}};
    endcase
    launch_s   = (launch_kind_s != LK_NONE);
    awvalid_d  = launch_s ? 1'b1 : awvalid_d;
    wvalid_d   = launch_s ? 1'b1 : wvalid_d;
    awaddr_d   = launch_s ? launch_addr_s : awaddr_d;
    wdata_d    = launch_s ? launch_data_s : wdata_d;
    wstrb_d    = launch_s ? {SW{1'b1}} : wstrb_d;

    state_d    = abort_s ? S_IDLE : state_d;
    busy_d     = abort_s ? 1'b0 : busy_d;
    error_d    = abort_s ? 1'b1 : error_d;
    err_code_d = abort_s ? abort_code_s : err_code_d;
  end

  // State and output registers.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state_q    <= S_IDLE;
      awvalid_q  <= 1'b0;  wvalid_q <= 1'b0;  bready_q <= 1'b0;
      arvalid_q  <= 1'b0;  rready_q <= 1'b0;
      awaddr_q   <= {ADDR_WIDTH{1'b0}};
      araddr_q   <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= {DATA_WIDTH{1'b0}};
      wstrb_q    <= {SW{1'b0}};
      busy_q     <= 1'b0;  done_q <= 1'b0;  error_q <= 1'b0;
      err_code_q <= 2'b00;
      len_q      <= {LW{1'b0}};
      pix_idx_q  <= {IW{1'b0}};
      poll_cnt_q <= {PW{1'b0}};
`ifdef LIGHTSHOW_SEQ_AUTO_REPEAT_EN
      rep_pend_q <= 1'b0;
      rep_cnt_q  <= {RW{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;  wvalid_q <= wvalid_d;  bready_q <= bready_d;
      arvalid_q  <= arvalid_d;  rready_q <= rready_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      busy_q     <= busy_d;  done_q <= done_d;  error_q <= error_d;
      err_code_q <= err_code_d;
      len_q      <= len_d;
      pix_idx_q  <= pix_idx_d;
      poll_cnt_q <= poll_cnt_d;
`ifdef LIGHTSHOW_SEQ_AUTO_REPEAT_EN
      rep_pend_q <= rep_pend_d;
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign o_awvalid  = awvalid_q;
  assign o_awaddr   = awaddr_q;
  assign o_wvalid   = wvalid_q;
  assign o_wdata    = wdata_q;
  assign o_wstrb    = wstrb_q;
  assign o_bready   = bready_q;
  assign o_arvalid  = arvalid_q;
  assign o_araddr   = araddr_q;
  assign o_rready   = rready_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_err_code = err_code_q;

endmodule

// File: tb/tb_lightshow_sequencer.sv
// Directed bench for lightshow_sequencer: a behavioural AXI-Lite slave checks each transaction
// against a queue of expected transactions pushed when a frame is started.
module tb_lightshow_sequencer;
  localparam int PC = 16;
  localparam int PL = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_pix_we;
  logic [4:0]  i_frame_len;
  logic [3:0]  i_pix_addr;
  logic [31:0] i_pix_data;
  logic        o_busy, o_done, o_error;
  logic [1:0]  o_err_code;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [31:0] o_awaddr, o_wdata, o_araddr, i_rdata;
  logic [3:0]  o_wstrb;
  logic [1:0]  i_bresp, i_rresp;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;

  typedef struct {bit is_rd; logic [31:0] addr; logic [31:0] data;} txn_t;
  txn_t        exp_q[$];
  logic [31:0] pix_m [PC];
  int checks = 0, errors = 0;

  // slave knobs and bookkeeping
  int aw_delay = 0, w_delay = 0, bresp_err_idx = -1, busy_left = 0;
  bit rresp_err = 1'b0;
  int aw_cnt = 0, w_cnt = 0, wr_idx = 0, aw_hs = 0, w_hs = 0, done_cnt = 0;
  bit aw_have = 1'b0, w_have = 1'b0;
  logic [31:0] aw_addr_l, w_data_l;

  always #5 clk = ~clk;

  lightshow_sequencer #(.POLL_LIMIT(PL)) dut (
    .i_axi_clk(clk), .i_axi_rst(rst_n),
    .i_start(i_start), .i_frame_len(i_frame_len),
    .i_pix_we(i_pix_we), .i_pix_addr(i_pix_addr), .i_pix_data(i_pix_data),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code),
    .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wstrb(o_wstrb), .o_wdata(o_wdata),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: decides ready/valid on the falling edge for the next rising edge.
  initial begin
    txn_t t;
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    i_arready = 1'b0; i_rvalid = 1'b0; i_rresp = 2'b00; i_rdata = 32'h0;
    forever begin
      @(negedge clk);
      i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
      i_arready = 1'b0; i_rvalid = 1'b0; i_rresp = 2'b00; i_rdata = 32'h0;
      if (!rst_n) begin
        aw_cnt = 0; w_cnt = 0; aw_have = 1'b0; w_have = 1'b0; wr_idx = 0;
      end else begin
        if (o_done) done_cnt++;
        if (o_awvalid) begin
          if (aw_cnt >= aw_delay) begin
            i_awready = 1'b1; aw_addr_l = o_awaddr; aw_have = 1'b1; aw_hs++; aw_cnt = 0;
          end else aw_cnt++;
        end
        if (o_wvalid) begin
          if (w_cnt >= w_delay) begin
            i_wready = 1'b1; w_data_l = o_wdata; w_have = 1'b1; w_hs++; w_cnt = 0;
            chk("wstrb", o_wstrb, 4'hF);
          end else w_cnt++;
        end
        if (o_bready) begin
          chk("bready_before_both", aw_have && w_have, 1'b1);
          i_bvalid = 1'b1;
          i_bresp  = (wr_idx == bresp_err_idx) ? 2'b10 : 2'b00;
          chk("txn_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("txn_kind_wr", t.is_rd, 1'b0);
            chk("wr_addr", aw_addr_l, t.addr);
            chk("wr_data", w_data_l, t.data);
          end
          wr_idx++; aw_have = 1'b0; w_have = 1'b0;
        end
        if (o_arvalid) begin
          i_arready = 1'b1;
          chk("txn_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("txn_kind_rd", t.is_rd, 1'b1);
            chk("rd_addr", o_araddr, t.addr);
          end
        end
        if (o_rready) begin
          i_rvalid = 1'b1;
          i_rresp  = rresp_err ? 2'b10 : 2'b00;
          i_rdata  = (busy_left > 0) ? 32'h1 : 32'h0;
          if (busy_left > 0) busy_left--;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic load_pix(input int idx, input logic [31:0] val);
    @(negedge clk);
    i_pix_we = 1'b1; i_pix_addr = 4'(idx); i_pix_data = val; pix_m[idx] = val;
    @(negedge clk);
    i_pix_we = 1'b0;
  endtask

  task automatic push_full(input int len_eff, input int nreads);
    exp_q.push_back('{1'b0, 32'h08, 32'd10});
    for (int n = 0; n < len_eff; n++) exp_q.push_back('{1'b0, 32'h40 + 32'(4 * n), pix_m[n]});
    exp_q.push_back('{1'b0, 32'h00, 32'h1});
    for (int n = 0; n < nreads; n++) exp_q.push_back('{1'b1, 32'h04, 32'h0});
  endtask

  task automatic start_frame(input logic [4:0] len);
    @(negedge clk);
    wr_idx = 0;
    i_frame_len = len; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1'b1);
    chk("error_cleared_by_start", o_error, 1'b0);
  endtask

  task automatic finish_frame(input string tag, input int done0, input int aw0, input int w0,
                              input int exp_done, input logic exp_err, input logic [1:0] exp_code,
                              input int exp_wr);
    int n = 0;
    while (o_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy_drop"}, o_busy, 1'b0);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - done0, exp_done);
    chk({tag, "_error"}, o_error, exp_err);
    chk({tag, "_err_code"}, o_err_code, exp_code);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_aw_count"}, aw_hs - aw0, exp_wr);
    chk({tag, "_w_count"}, w_hs - w0, exp_wr);
    exp_q.delete();
  endtask

  task automatic run(input string tag, input logic [4:0] len, input int exp_done,
                     input logic exp_err, input logic [1:0] exp_code, input int exp_wr);
    int d0 = done_cnt, a0 = aw_hs, w0 = w_hs;
    start_frame(len);
    finish_frame(tag, d0, a0, w0, exp_done, exp_err, exp_code, exp_wr);
  endtask

  initial begin
    int n;
    int d0, a0, w0;
    rst_n = 1'b0; i_start = 1'b0; i_frame_len = 5'd0;
    i_pix_we = 1'b0; i_pix_addr = 4'd0; i_pix_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", o_awvalid, 1'b0);
    chk("rst_wvalid", o_wvalid, 1'b0);
    chk("rst_arvalid", o_arvalid, 1'b0);
    chk("rst_ready", {o_bready, o_rready}, 2'b00);
    chk("rst_flags", {o_busy, o_done, o_error, o_err_code}, 5'd0);
    chk("rst_addr_data", {o_awaddr, o_wdata}, 64'h0);
    rst_n = 1'b1;

    // 1: four pixels, status busy for three reads
    for (int i = 0; i < 4; i++) load_pix(i, 32'hA0 + 32'(i));
    busy_left = 3; push_full(4, 4);
    run("t1", 5'd4, 1, 1'b0, 2'b00, 6);

    // 2: delayed AW, then delayed W
    aw_delay = 3; busy_left = 0; push_full(2, 1);
    run("t2a", 5'd2, 1, 1'b0, 2'b00, 4);
    aw_delay = 0; w_delay = 3; push_full(2, 1);
    run("t2b", 5'd2, 1, 1'b0, 2'b00, 4);
    w_delay = 0;

    // 3: bad bresp on the first pixel write
    bresp_err_idx = 1;
    exp_q.push_back('{1'b0, 32'h08, 32'd10});
    exp_q.push_back('{1'b0, 32'h40, pix_m[0]});
    run("t3", 5'd4, 0, 1'b1, 2'b01, 2);
    bresp_err_idx = -1;

    // 4: status stuck busy, then a clean frame clears the error
    busy_left = 1000; push_full(1, PL);
    run("t4", 5'd1, 0, 1'b1, 2'b11, 3);
    busy_left = 0; push_full(1, 1);
    run("t4b", 5'd1, 1, 1'b0, 2'b00, 3);

    // bad rresp on the status read
    rresp_err = 1'b1; push_full(1, 1);
    run("t4c", 5'd1, 0, 1'b1, 2'b10, 3);
    rresp_err = 1'b0;

    // 5: empty frame, then an oversized frame clamped to the buffer depth
    for (int i = 0; i < PC; i++) load_pix(i, $urandom);
    push_full(0, 1);
    run("t5a", 5'd0, 1, 1'b0, 2'b00, 2);
    push_full(PC, 1);
    run("t5b", 5'd20, 1, 1'b0, 2'b00, PC + 2);

    // 6: reset while a pixel address is being offered
    busy_left = 0; push_full(4, 1);
    start_frame(5'd4);
    n = 0;
    while (!(o_awvalid && o_awaddr == 32'h44) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_pixel1", o_awvalid && o_awaddr == 32'h44, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valids", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready}, 5'd0);
    chk("t6_async_flags", {o_busy, o_done, o_error, o_err_code}, 5'd0);
    chk("t6_async_addr", {o_awaddr, o_araddr}, 64'h0);
    chk("t6_async_wdata", o_wdata, 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_cnt; a0 = aw_hs; w0 = w_hs;
    busy_left = 1; push_full(4, 2);
    start_frame(5'd4);
    finish_frame("t6", d0, a0, w0, 1, 1'b0, 2'b00, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
